// File: rtl/serial_accumulator.sv
// rtl/serial_accumulator.sv - bit-serial add/subtract accumulator with valid/ready serial streams
//
// Each operation shifts a WIDTH-bit operand in LSB first (SIPO), adds it to or
// subtracts it from the accumulator in a single ADD cycle, then shifts the
// result out LSB first (PISO).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op_sub       begin an operation (IDLE only); 0 = add, 1 = subtract
//   clear               zero the accumulator (IDLE only)
//   in_bit/in_valid     serial operand stream; in_ready high in LOAD
//   out_bit/out_valid   serial result stream; out_valid high in SHIFT_OUT
//   out_ready           downstream accepts out_bit this cycle
//   busy, done          not idle; one-cycle pulse after the last result bit
//   acc, carry, ovf     accumulator, carry/borrow and signed overflow of last op
module serial_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    ADD       = 2'd2,
    SHIFT_OUT = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sipo;
  logic [WIDTH-1:0] piso;
  logic [CNT_W-1:0] cnt;
  logic             op_sub_q;
  logic             done_q;

  logic             in_accept;
  logic             out_accept;
  logic             last_bit;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  assign in_accept  = (state == LOAD) && in_valid;
  assign out_accept = (state == SHIFT_OUT) && out_ready;
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));

  // Subtraction is acc + ~operand + 1; the +1 rides in as the carry-in term.
  assign addend = op_sub_q ? ~sipo : sipo;
  assign sum    = {1'b0, acc} + {1'b0, addend} + {{WIDTH{1'b0}}, op_sub_q};

  // Outputs decode straight from the state so an asynchronous reset drops them at once.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == SHIFT_OUT);
  assign out_bit   = (state == SHIFT_OUT) ? piso[0] : 1'b0;
  assign busy      = (state != IDLE);
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = LOAD;
      LOAD:      if (in_accept && last_bit) state_nxt = ADD;
      ADD:       state_nxt = SHIFT_OUT;
      SHIFT_OUT: if (out_accept && last_bit) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      sipo     <= '0;
      piso     <= '0;
      cnt      <= '0;
      op_sub_q <= 1'b0;
      carry    <= 1'b0;
      ovf      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // done is registered so it lands in the first IDLE cycle after the last bit.
      done_q <= out_accept && last_bit;
      case (state)
        IDLE: begin
          if (clear) acc <= '0;
          if (start) begin
            op_sub_q <= op_sub;
            cnt      <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            sipo <= {in_bit, sipo[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
          end
        end
        ADD: begin
          acc   <= sum[WIDTH-1:0];
          piso  <= sum[WIDTH-1:0];
          carry <= op_sub_q ? ~sum[WIDTH] : sum[WIDTH];
          ovf   <= (acc[WIDTH-1] == addend[WIDTH-1]) &&
                   (sum[WIDTH-1] != acc[WIDTH-1]);
          cnt   <= '0;
        end
        SHIFT_OUT: begin
          if (out_ready) begin
            piso <= {1'b0, piso[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_accumulator.sv
// tb/tb_serial_accumulator.sv - directed self-checking bench for serial_accumulator (WIDTH 4 and 8)
module tb_serial_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, op_sub, clear, in_bit, in_valid, out_ready, sel8;

  logic       start4, clear4, in_valid4, out_ready4;
  logic       in_ready4, out_bit4, out_valid4, busy4, done4, carry4, ovf4;
  logic [3:0] acc4;
  logic       start8, clear8, in_valid8, out_ready8;
  logic       in_ready8, out_bit8, out_valid8, busy8, done8, carry8, ovf8;
  logic [7:0] acc8;

  assign start4     = sel8 ? 1'b0 : start;
  assign clear4     = sel8 ? 1'b0 : clear;
  assign in_valid4  = sel8 ? 1'b0 : in_valid;
  assign out_ready4 = sel8 ? 1'b0 : out_ready;
  assign start8     = sel8 ? start : 1'b0;
  assign clear8     = sel8 ? clear : 1'b0;
  assign in_valid8  = sel8 ? in_valid : 1'b0;
  assign out_ready8 = sel8 ? out_ready : 1'b0;

  logic       in_ready, out_bit, out_valid, busy, done, carry, ovf;
  logic [7:0] acc;
  assign in_ready  = sel8 ? in_ready8  : in_ready4;
  assign out_bit   = sel8 ? out_bit8   : out_bit4;
  assign out_valid = sel8 ? out_valid8 : out_valid4;
  assign busy      = sel8 ? busy8      : busy4;
  assign done      = sel8 ? done8      : done4;
  assign carry     = sel8 ? carry8     : carry4;
  assign ovf       = sel8 ? ovf8       : ovf4;
  assign acc       = sel8 ? acc8       : {4'b0, acc4};

  serial_accumulator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_sub(op_sub), .clear(clear4),
    .in_bit(in_bit), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_bit(out_bit4), .out_valid(out_valid4), .out_ready(out_ready4),
    .busy(busy4), .done(done4), .acc(acc4), .carry(carry4), .ovf(ovf4)
  );

  serial_accumulator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_sub(op_sub), .clear(clear8),
    .in_bit(in_bit), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_bit(out_bit8), .out_valid(out_valid8), .out_ready(out_ready8),
    .busy(busy8), .done(done8), .acc(acc8), .carry(carry8), .ovf(ovf8)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // One full operation starting in IDLE (or a done cycle). is_at/os_at insert
  // input/output stalls before that bit index; poke pulses start+clear mid-op.
  // Ends on the cycle where done must be high.
  task automatic run_op(input logic sub, input logic [7:0] opnd, input int w,
                        input int is_at, input int is_len, input int os_at, input int os_len,
                        input logic poke, input logic [7:0] exp_res);
    logic [7:0] res;
    res    = '0;
    start  = 1'b1;
    op_sub = sub;
    tick();
    start  = 1'b0;
    clear  = 1'b0;
    op_sub = ~sub;
    for (int i = 0; i < w; i++) begin
      if (i == is_at) begin
        for (int k = 0; k < is_len; k++) begin
          in_valid = 1'b0;
          tick();
          check("stall_in_ready", in_ready, 1);
        end
      end
      check("in_ready", in_ready, 1);
      check("load_out_valid", out_valid, 0);
      in_valid = 1'b1;
      in_bit   = opnd[i];
      if (poke && i == 1) begin
        start = 1'b1;
        clear = 1'b1;
      end
      tick();
      start = 1'b0;
      clear = 1'b0;
    end
    in_valid = 1'b0;
    check("add_in_ready", in_ready, 0);
    check("add_out_valid", out_valid, 0);
    check("add_busy", busy, 1);
    tick();
    for (int j = 0; j < w; j++) begin
      if (j == os_at) begin
        for (int k = 0; k < os_len; k++) begin
          out_ready = 1'b0;
          tick();
          check("hold_out_valid", out_valid, 1);
          check("hold_out_bit", out_bit, exp_res[j]);
        end
      end
      check("out_valid", out_valid, 1);
      check("early_done", done, 0);
      res[j]    = out_bit;
      out_ready = 1'b1;
      if (poke && j == 1) begin
        start = 1'b1;
        clear = 1'b1;
      end
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      clear     = 1'b0;
    end
    check("result_bits", res, exp_res);
    check("done", done, 1);
    check("done_busy", busy, 0);
    check("done_out_valid", out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; clear = 1'b0;
    in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel8 = 1'b0;
    tick();
    tick();
    check("rst_acc", acc, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_carry_ovf", {carry, ovf}, 0);
    check("rst_acc8", acc8, 0);
    rst_n = 1'b1;
    tick();

    // add 3, add 5 -> 8, signed overflow
    run_op(1'b0, 8'd3, 4, -1, 0, -1, 0, 1'b0, 8'd3);
    check("t1a_acc", acc, 3);
    run_op(1'b0, 8'd5, 4, -1, 0, -1, 0, 1'b0, 8'd8);
    check("t1_acc", acc, 8);
    check("t1_carry", carry, 0);
    check("t1_ovf", ovf, 1);
    tick();
    check("t1_done_pulse", done, 0);

    // add 9 -> 1; sub 2 -> 15; sub 15 -> 0 (back-to-back starts in done cycle)
    run_op(1'b0, 8'd9, 4, -1, 0, -1, 0, 1'b0, 8'd1);
    check("t2a_acc", acc, 1);
    check("t2a_co", {carry, ovf}, 2'b11);
    run_op(1'b1, 8'd2, 4, -1, 0, -1, 0, 1'b0, 8'd15);
    check("t2b_acc", acc, 15);
    check("t2b_co", {carry, ovf}, 2'b10);
    run_op(1'b1, 8'd15, 4, -1, 0, -1, 0, 1'b0, 8'd0);
    check("t2c_acc", acc, 0);
    check("t2c_co", {carry, ovf}, 2'b00);

    // stalls: 3 input cycles after bit 1, 2 output cycles at bit 2
    run_op(1'b0, 8'd11, 4, 2, 3, 2, 2, 1'b0, 8'd11);
    check("t3_acc", acc, 11);
    check("t3_co", {carry, ovf}, 2'b00);

    // start/clear pulsed mid-operation are ignored
    run_op(1'b0, 8'd2, 4, -1, 0, -1, 0, 1'b1, 8'd13);
    check("t4a_acc", acc, 13);
    tick();
    do_clear();
    check("t4_clear", acc, 0);
    run_op(1'b0, 8'd7, 4, -1, 0, -1, 0, 1'b0, 8'd7);
    check("t4b_acc", acc, 7);
    clear = 1'b1;
    run_op(1'b0, 8'd4, 4, -1, 0, -1, 0, 1'b0, 8'd4);
    check("t4c_acc", acc, 4);

    // reset during SHIFT_OUT
    start = 1'b1; op_sub = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_bit   = i[0];
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t5_shift", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_bit", out_bit, 0);
    check("t5_busy", busy, 0);
    check("t5_acc", acc, 0);
    check("t5_co", {carry, ovf}, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t5_no_done", done, 0);
      tick();
    end
    run_op(1'b0, 8'd6, 4, -1, 0, -1, 0, 1'b0, 8'd6);
    check("t5_acc6", acc, 6);

    // WIDTH=8 instance
    sel8 = 1'b1;
    tick();
    run_op(1'b0, 8'd200, 8, -1, 0, -1, 0, 1'b0, 8'd200);
    check("t6a_acc", acc, 200);
    run_op(1'b0, 8'd100, 8, -1, 0, -1, 0, 1'b0, 8'd44);
    check("t6b_acc", acc, 44);
    check("t6b_co", {carry, ovf}, 2'b10);
    run_op(1'b1, 8'd45, 8, -1, 0, -1, 0, 1'b0, 8'd255);
    check("t6c_acc", acc, 255);
    check("t6c_co", {carry, ovf}, 2'b10);
    check("t6_acc4_untouched", acc4, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_accumulator.md
Name: serial_accumulator

Overview:
Parametrised bit-serial accumulate unit. It is the next generation of the SIPO → adder → PISO datapath. Each operation shifts a WIDTH-bit operand in serially (LSB first), adds it to or subtracts it from an internal accumulator register, and shifts the result out serially (LSB first). Both serial streams use valid/ready handshakes, and the unit reports carry/borrow and signed overflow.

Parameters:
WIDTH, 4, operand/accumulator width in bits (≥2)
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin an operation; sampled only in IDLE
op_sub  input  1  0 = add, 1 = subtract; captured with start
clear  input  1  synchronous accumulator clear; honoured only in IDLE
in_bit  input  1  serial operand bit
in_valid  input  1  in_bit is valid this cycle
in_ready  output  1  unit accepts in_bit (high only in LOAD)
out_bit  output  1  serial result bit
out_valid  output  1  out_bit is valid (high only in SHIFT_OUT)
out_ready  input  1  downstream consumes out_bit this cycle
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the last result bit is accepted
acc  output  WIDTH  accumulator contents (parallel view)
carry  output  1  add: carry-out; sub: borrow (acc < operand, unsigned); per operation
ovf  output  1  signed two's-complement overflow of the last operation

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc, shift registers, counter, carry, ovf = 0.
  - in_ready, out_valid, out_bit, busy, done = 0.
  - Reset asserted mid-operation abandons the operation; no done pulse is issued.
- State IDLE:
  - clear=1 sets acc=0 on the next edge.
  - start=1 latches op_sub, zeroes the counter and moves to LOAD.
  - clear and start in the same cycle: both take effect, so the operation uses acc=0.
- State LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1, the SIPO shifts right with in_bit entering the MSB, and the counter increments.
  - in_valid=0 stalls the unit, with no shift and no count.
  - When the WIDTH-th bit is accepted, the next state is ADD.
  - start and clear are ignored in every state except IDLE.
- State ADD (exactly 1 cycle):
  - r = acc + operand (add) or acc + ~operand + 1 (sub), computed WIDTH+1 wide.
  - acc ← r[WIDTH-1:0] and PISO ← r[WIDTH-1:0].
  - carry ← r[WIDTH] for add, ~r[WIDTH] for sub.
  - ovf ← (sign of acc == sign of effective addend) && (sign of result != sign of acc), where the effective addend is the operand for add and ~operand for sub.
  - Counter zeroed; next state SHIFT_OUT.
- State SHIFT_OUT:
  - out_valid=1 and out_bit=PISO[0].
  - On out_valid && out_ready, PISO shifts right and the counter increments.
  - out_ready=0 holds out_bit stable.
  - After the WIDTH-th accepted bit, the next state is IDLE and done=1 for that single cycle.
- Latency with no stalls:
  - start at cycle 0; LOAD accepts bits in cycles 1..WIDTH; ADD in cycle WIDTH+1.
  - Result bits are output in cycles WIDTH+2..2·WIDTH+1; done in cycle 2·WIDTH+2.
  - A new start is accepted in the done cycle.
- Registered values: acc, carry and ovf change only in ADD (or on clear/reset). Wrap-around is modulo 2^WIDTH.

Test Plan:
1. WIDTH=4, reset, then add 3 followed by add 5 (bits 1,0,1,0) → acc=8, out_bit sequence 0,0,0,1, carry=0, ovf=1, done pulses at cycle 10 of the second op.
2. From acc=8, add 9 → acc=1, carry=1, ovf=1; then sub 2 → acc=15, carry=1 (borrow), ovf=0; then sub 15 → acc=0, carry=0, ovf=0.
3. Stalls: in_valid low for 3 cycles after bit 1, and out_ready low for 2 cycles at bit 2 → the same result as without stalls; out_bit is held while out_ready=0; cycle count extends by exactly 5.
4. Ignored controls: start and clear pulsed during LOAD/SHIFT_OUT → no effect. clear+start together in IDLE with acc=7, add 4 → acc=4.
5. Reset mid-operation: rst_n low during SHIFT_OUT → all outputs 0 immediately (async), no done; a new op add 6 → acc=6.
6. WIDTH=8: acc=200, add 100 → acc=44, carry=1, ovf=0; sub 45 from 44 → acc=255, carry=1, ovf=0.
